// File: rtl/fifo_packer.sv
// Packs consecutive show-ahead FIFO entries into one wide word with a valid/ready output.
// Optional idle-timeout flush of partial words is enabled by defining FIFO_PACKER_FLUSH_EN.
module fifo_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             fifo_dataout,
    input  logic                              fifo_val,
    output logic                              fifo_read,
    output logic [DATA_WIDTH*RATIO-1:0]       word_out,
    output logic                              word_val,
    input  logic                              word_ready,
    output logic [$clog2(RATIO+1)-1:0]        word_cnt
);

    localparam int CW = $clog2(RATIO + 1);
    localparam int WW = DATA_WIDTH * RATIO;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] word_cnt_q, word_cnt_d;
    logic [WW-1:0] asm_q, asm_d;
    logic          val_q, val_d;
    logic          accept_s;
    logic          fifo_read_s;
    logic [CW-1:0] base_cnt_s;

`ifdef FIFO_PACKER_FLUSH_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_q, idle_d;
`endif

    // Next-state: accept clears the word, then a pop lands in lane base_cnt_s.
    always_comb begin
        accept_s    = val_q & word_ready;
        fifo_read_s = fifo_val & (~val_q | word_ready) & ~reset;
        base_cnt_s  = accept_s ? {CW{1'b0}} : cnt_q;
        asm_d       = accept_s ? {WW{1'b0}} : asm_q;
        val_d       = accept_s ? 1'b0 : val_q;
        cnt_d       = base_cnt_s;
        if (fifo_read_s) begin
            for (int i = 0; i < RATIO; i++) begin
                if (base_cnt_s == CW'(i)) begin
                    asm_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_dataout;
                end else begin
                    asm_d[i*DATA_WIDTH +: DATA_WIDTH] = asm_d[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            cnt_d = base_cnt_s + CW'(1);
            if (cnt_d == CW'(RATIO)) begin
                val_d = 1'b1;
            end else begin
                val_d = val_d;
            end
        end else begin
            cnt_d = base_cnt_s;
        end
`ifdef FIFO_PACKER_FLUSH_EN
        // The idle count only advances while a partial word sits untouched.
        if (fifo_read_s || accept_s) begin
            idle_d = {IW{1'b0}};
        end else if (!val_q && (cnt_q != {CW{1'b0}}) && (cnt_q < CW'(RATIO))) begin
            idle_d = idle_q + IW'(1);
            if (idle_d == IW'(TIMEOUT)) begin
                val_d = 1'b1;
            end else begin
                val_d = val_d;
            end
        end else begin
            idle_d = idle_q;
        end
`endif
        word_cnt_d = val_d ? cnt_d : {CW{1'b0}};
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= {CW{1'b0}};
            word_cnt_q <= {CW{1'b0}};
            asm_q      <= {WW{1'b0}};
            val_q      <= 1'b0;
`ifdef FIFO_PACKER_FLUSH_EN
            idle_q     <= {IW{1'b0}};
`endif
        end else begin
            cnt_q      <= cnt_d;
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
            val_q      <= val_d;
`ifdef FIFO_PACKER_FLUSH_EN
            idle_q     <= idle_d;
`endif
        end
    end

    assign fifo_read = fifo_read_s;
    assign word_out  = asm_q;
    assign word_val  = val_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_fifo_packer.sv
// Scoreboard bench for fifo_packer: a queue-based FIFO model feeds the DUT, a monitor
// compares every accepted word against expected words queued by the directed stimulus.
module tb_fifo_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  fifo_dataout = 8'h00;
    logic        fifo_val = 1'b0;
    logic        fifo_read;
    logic [31:0] word_out;
    logic        word_val;
    logic        word_ready = 1'b0;
    logic [2:0]  word_cnt;

    fifo_packer dut (
        .clk(clk), .reset(reset), .fifo_dataout(fifo_dataout), .fifo_val(fifo_val),
        .fifo_read(fifo_read), .word_out(word_out), .word_val(word_val),
        .word_ready(word_ready), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0]  fifo_q[$];
    logic [31:0] exp_word_q[$];
    logic [2:0]  exp_cnt_q[$];
    logic        rd_pend = 1'b0;
    logic        prev_val = 1'b0;
    int cyc = 0, rd_total = 0, rd_run = 0, rd_run_max = 0;
    int last_pop_cyc = 0, val_rise_cyc = 0, val_cycles = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // FIFO model: pops the head the DUT consumed, then re-presents the head.
    always begin
        @(posedge clk);
        #2;
        if (rd_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_val     = (fifo_q.size() > 0);
        fifo_dataout = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end

    // Monitor: samples on the falling edge and scores accepted words.
    always @(negedge clk) begin
        cyc++;
        rd_pend = fifo_read;
        if (fifo_read) begin
            rd_total++;
            rd_run++;
            last_pop_cyc = cyc;
            if (rd_run > rd_run_max) rd_run_max = rd_run;
        end else begin
            rd_run = 0;
        end
        if (word_val) val_cycles++;
        if (word_val && !prev_val) val_rise_cyc = cyc;
        prev_val = word_val;
        if (!word_val && !reset) check("cnt_zero_idle", 64'(word_cnt), 64'd0);
        if (word_val && word_ready) begin
            if (exp_word_q.size() == 0) begin
                check("unexpected_word", 64'(word_out), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("word_out", 64'(word_out), 64'(exp_word_q.pop_front()));
                check("word_cnt", 64'(word_cnt), 64'(exp_cnt_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        fifo_q.push_back(d);
    endtask

    task automatic expect_word(input logic [31:0] w, input logic [2:0] c);
        exp_word_q.push_back(w);
        exp_cnt_q.push_back(c);
    endtask

    task automatic clear_stats();
        rd_total = 0; rd_run_max = 0; val_cycles = 0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_word_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_word_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // Reset state, with an entry waiting so fifo_read must stay low.
        push(8'h99);
        repeat (3) @(negedge clk);
        check("rst_fifo_read", 64'(fifo_read), 64'd0);
        check("rst_word_val", 64'(word_val), 64'd0);
        check("rst_word_out", 64'(word_out), 64'd0);
        check("rst_word_cnt", 64'(word_cnt), 64'd0);
        void'(fifo_q.pop_front());
        step();
        reset = 1'b0;
        word_ready = 1'b1;
        step();

        // Single word: four pops then 0x44332211.
        clear_stats();
        expect_word(32'h44332211, 3'd4);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_drain("t1_drain", 30);
        check("t1_rd_total", 64'(rd_total), 64'd4);
        check("t1_rd_run", 64'(rd_run_max), 64'd4);
        check("t1_val_cycles", 64'(val_cycles), 64'd1);

        // Back-to-back words, no bubble at the boundary.
        clear_stats();
        expect_word(32'h04030201, 3'd4);
        expect_word(32'h08070605, 3'd4);
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_drain("t2_drain", 40);
        check("t2_rd_run", 64'(rd_run_max), 64'd8);
        check("t2_rd_total", 64'(rd_total), 64'd8);

        // Stall with a full word pending, then release pops into lane 0.
        word_ready = 1'b0;
        expect_word(32'hE4E3E2E1, 3'd4);
        expect_word(32'hE8E7E6E5, 3'd4);
        push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4); push(8'hE5);
        for (int n = 0; n < 20 && !word_val; n++) @(negedge clk);
        check("t3_val_rise", 64'(word_val), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_stall_read", 64'(fifo_read), 64'd0);
            check("t3_stall_word", 64'(word_out), 64'hE4E3E2E1);
            check("t3_stall_cnt", 64'(word_cnt), 64'd4);
        end
        step();
        word_ready = 1'b1;
        @(negedge clk);
        check("t3_release_read", 64'(fifo_read), 64'd1);
        @(negedge clk);
        check("t3_lane0", 64'(word_out), 64'h000000E5);
        check("t3_val_low", 64'(word_val), 64'd0);
        step();
        push(8'hE6); push(8'hE7); push(8'hE8);
        wait_drain("t3_drain", 30);

        // Reset mid-word discards the partial lanes.
        push(8'h55); push(8'h66); push(8'h77);
        repeat (6) step();
        reset = 1'b1;
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        expect_word(32'hA3A2A1A0, 3'd4);
        @(negedge clk);
        check("t4_rst_read", 64'(fifo_read), 64'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t4_post_val", 64'(word_val), 64'd0);
        check("t4_post_word", 64'(word_out), 64'd0);
        check("t4_post_cnt", 64'(word_cnt), 64'd0);
        wait_drain("t4_drain", 30);

        // Partial word: flushed after the timeout, or held forever without the flush.
        clear_stats();
`ifdef FIFO_PACKER_FLUSH_EN
        expect_word(32'h0000BBAA, 3'd2);
        push(8'hAA); push(8'hBB);
        wait_drain("t5_flush_drain", 40);
        // Pop sampled at negedge k happens on the next edge; word_val is seen 8 edges later.
        check("t5_flush_delay", 64'(val_rise_cyc - last_pop_cyc), 64'd9);
        check("t5_val_cycles", 64'(val_cycles), 64'd1);
`else
        push(8'hAA); push(8'hBB);
        repeat (100) @(negedge clk);
        check("t5_no_flush", 64'(val_cycles), 64'd0);
        expect_word(32'hDDCCBBAA, 3'd4);
        step();
        push(8'hCC); push(8'hDD);
        wait_drain("t5_full_drain", 30);
`endif

        check("final_sb_empty", 64'(exp_word_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_packer.md
# fifo_packer

Width up-converter that drains the ring FIFO and packs consecutive FIFO entries into one wide output word with a valid/ready handshake. It sits directly downstream of the ring FIFO: it watches the FIFO's show-ahead data and non-empty flag, pops entries with a single-cycle read strobe, and presents packed words to the consumer. An optional idle timeout flushes a partially filled word.

## Interface
Parameters:
- DATA_WIDTH, 8: width of one FIFO entry (lane).
- RATIO, 4: lanes per output word; must be ≥ 2.
- TIMEOUT, 8: idle cycles before a partial word is flushed; must be ≥ 1. Used only with FIFO_PACKER_FLUSH_EN.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- fifo_dataout  in  DATA_WIDTH  FIFO head entry, show-ahead (valid whenever fifo_val=1).
- fifo_val  in  1  FIFO non-empty.
- fifo_read  out  1  pop strobe; head is consumed on the clock edge where this is 1.
- word_out  out  DATA_WIDTH*RATIO  packed word; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- word_val  out  1  word_out and word_cnt are valid.
- word_ready  in  1  consumer accepts the word on the edge where word_val and word_ready are both 1.
- word_cnt  out  $clog2(RATIO+1)  number of valid lanes in word_out (1..RATIO).

## Operation
- State: lane count `cnt` (0..RATIO), assembly register, output-valid flag; the idle counter exists only with FIFO_PACKER_FLUSH_EN.
- fifo_read = fifo_val & (!word_val | word_ready). This path is combinational from word_ready and fifo_val.
- Pop: fifo_dataout is written into lane `cnt` (with `cnt` = 0 if the word is being accepted in that cycle), and `cnt` increments.
- Packing order: the first entry goes to lane 0 (least significant bits).
- Fill: when `cnt` reaches RATIO, word_val=1 and word_cnt=RATIO. Further pops stop until the word is accepted.
- Accept edge: `cnt` and the assembly register clear to 0. A pop on the same edge lands in lane 0 and sets `cnt`=1, so sustained throughput is one entry per cycle.
- Stall: while word_val=1 and word_ready=0, word_out, word_cnt and word_val stay stable and fifo_read=0.
- Unused lanes always read 0.
- fifo_val=0: no pop, and the state holds (apart from the idle counter).
- Reset (at any point, including mid-word or while word_val=1): partial data is discarded, `cnt`=0, and the idle counter is 0.

## Timing
- Output values during and after reset: fifo_read=0 (while reset is held), word_val=0, word_out=0, word_cnt=0.
- Latency: if the RATIO-th pop happens on edge N, word_val=1 in the cycle after edge N.
- word_val falls on the accept edge unless a flush or fill completes on that same edge (possible only if RATIO pops are already done, which cannot happen on the accept edge itself). In practice word_val is low for at least RATIO-1 cycles between full words.
- word_cnt is valid only while word_val=1. Otherwise it is 0.

## Configuration
- FIFO_PACKER_FLUSH_EN defined:
  - Idle counter increments each cycle with 0 < `cnt` < RATIO, word_val=0 and no pop.
  - Counter clears on any pop, on accept, and on reset.
  - When the counter reaches TIMEOUT, the partial word is presented: word_val=1, word_cnt=`cnt`, unfilled lanes 0. Pops stop until it is accepted.
- FIFO_PACKER_FLUSH_EN undefined:
  - No idle counter.
  - Partial words wait indefinitely for more entries.
  - word_cnt is RATIO whenever word_val=1.

## Test plan
- Defaults; FIFO holds 0x11,0x22,0x33,0x44; word_ready=1 → four consecutive fifo_read pulses, then word_val=1 for one cycle with word_out=0x44332211 and word_cnt=4.
- 8 entries 0x01..0x08 streamed back-to-back, word_ready=1 → 0x04030201 then 0x08070605. fifo_read stays high for 8 consecutive cycles (no bubble at the word boundary).
- Full word pending, word_ready=0 for 5 cycles while fifo_val=1 → fifo_read=0 and word_out stable throughout. Raising word_ready pops the next entry into lane 0 on the same edge.
- 3 entries loaded, then reset pulsed for 1 cycle, then 4 entries 0xA0..0xA3 → first word is 0xA3A2A1A0 with no stale lanes. Outputs read 0 during reset.
- FIFO_PACKER_FLUSH_EN, TIMEOUT=8: 2 entries 0xAA,0xBB, then fifo_val=0 → word_val=1 8 cycles after the last pop, word_out=0x0000BBAA, word_cnt=2.
- Without FIFO_PACKER_FLUSH_EN, same stimulus → word_val stays 0 for 100 cycles. Two more entries then produce a full word with word_cnt=4.
